// File: rtl/me_lsu_pkg.sv
// me_lsu_pkg -- shared definitions for the memory-stage load/store engine.
//   lsu_state_e      : LSU sequencing states
//   MASK_B/H/W/D     : unshifted byte-enable masks for byte/half/word/double
//   STALL_*          : stall-control codes; mem_stall_req requests STALL_KEEP
package me_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    localparam logic [1:0] STALL_NORMAL = 2'd0;
    localparam logic [1:0] STALL_KEEP   = 2'd1;
    localparam logic [1:0] STALL_FLUSH  = 2'd2;

endpackage

// File: rtl/me_lsu_load_ext.sv
// me_load_ext -- combinational shift-and-extend of a loaded bus word.
//   i_rdata  : full aligned bus word
//   i_off    : byte offset of the access within the word
//   i_mask   : unshifted size mask (MASK_B/H/W/D)
//   i_ext_un : 1 = zero-extend, 0 = sign-extend
//   o_data   : LSB-aligned, extended load result
module me_load_ext
    import me_lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0]   i_rdata,
    input  logic [OFF_W-1:0]    i_off,
    input  logic [DATA_W/8-1:0] i_mask,
    input  logic                i_ext_un,
    output logic [DATA_W-1:0]   o_data
);

    logic [DATA_W-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        case (i_mask)
            MASK_B:  o_data = {{(DATA_W-8){~i_ext_un & w_shifted[7]}},   w_shifted[7:0]};
            MASK_H:  o_data = {{(DATA_W-16){~i_ext_un & w_shifted[15]}}, w_shifted[15:0]};
            MASK_W:  o_data = {{(DATA_W-32){~i_ext_un & w_shifted[31]}}, w_shifted[31:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/me_lsu.sv
// me_lsu -- memory-stage load/store engine. Takes one memory instruction from
// the EX/MEM register, issues a single data-bus request, waits for the
// response, aligns/extends load data and holds EX/MEM until the access is done.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   me_*                     EX/MEM outputs: rena/wena, ext_un, byte_enable,
//                            alu_result (address), new_rs2_data, inst_valid
//   dreq_*                   data-bus request (valid/ready, addr, wen, wdata, wstrb)
//   dresp_valid/rdata        data-bus response, one-cycle pulse
//   mem_rdata, mem_done      load result and its one-cycle completion pulse
//   mem_stall_req            hold EX/MEM (STALL_KEEP) while high
//   mem_misalign             only with MISALIGN_CHECK_EN: pulses with mem_done
//
// Build option: define MISALIGN_CHECK_EN to reject misaligned accesses
// without a bus transfer; otherwise lanes past the word end are truncated.
//
// state | meaning
// IDLE  | no access in flight; capture a new memory op when one is present
// REQ   | bus request presented, waiting for dreq_ready
// WAIT  | request accepted, waiting for dresp_valid
// DONE  | access complete, mem_done pulses, EX/MEM advances this cycle
module me_lsu
    import me_lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                me_mem_rena,
    input  logic                me_mem_wena,
    input  logic                me_mem_ext_un,
    input  logic [DATA_W/8-1:0] me_mem_byte_enable,
    input  logic [ADDR_W-1:0]   me_alu_result,
    input  logic [DATA_W-1:0]   me_new_rs2_data,
    input  logic                me_inst_valid,
    output logic                dreq_valid,
    input  logic                dreq_ready,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic                dreq_wen,
    output logic [DATA_W-1:0]   dreq_wdata,
    output logic [DATA_W/8-1:0] dreq_wstrb,
    input  logic                dresp_valid,
    input  logic [DATA_W-1:0]   dresp_rdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_done,
    output logic                mem_stall_req
`ifdef MISALIGN_CHECK_EN
    ,
    output logic                mem_misalign
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    lsu_state_e          r_state;
    lsu_state_e          w_state_nxt;
    logic                w_op;
    logic                w_skip_bus;
    logic [OFF_W-1:0]    w_off;
    logic [STRB_W-1:0]   w_strb;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_load_data;

    logic [ADDR_W-1:0]   r_addr;
    logic [OFF_W-1:0]    r_off;
    logic [STRB_W-1:0]   r_mask;
    logic                r_ext_un;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [DATA_W-1:0]   r_rdata;

    // Both rena and wena high is a store: wen follows wena alone.
    assign w_op    = me_inst_valid & (me_mem_rena | me_mem_wena);
    assign w_off   = me_alu_result[OFF_W-1:0];
    assign w_strb  = me_mem_byte_enable << w_off;
    assign w_wdata = me_new_rs2_data << {w_off, 3'b000};

`ifdef MISALIGN_CHECK_EN
    logic                w_misalign;
    logic                w_carry;
    logic [OFF_W-1:0]    w_size_lsbs;
    logic                r_misalign;

    // Lanes shifted past the top of the word.
    assign w_carry = |(((2*STRB_W)'(me_mem_byte_enable) << w_off) >> STRB_W);

    always_comb begin
        case (me_mem_byte_enable)
            MASK_B:  w_size_lsbs = '0;
            MASK_H:  w_size_lsbs = OFF_W'(1);
            MASK_W:  w_size_lsbs = OFF_W'(3);
            default: w_size_lsbs = '1;
        endcase
    end

    assign w_misalign   = w_carry | (|(w_off & w_size_lsbs));
    assign w_skip_bus   = w_misalign;
    assign mem_misalign = r_misalign & (r_state == LSU_DONE);
`else
    assign w_skip_bus = 1'b0;
`endif

    me_load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .i_rdata  (dresp_rdata),
        .i_off    (r_off),
        .i_mask   (r_mask),
        .i_ext_un (r_ext_un),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        dreq_valid    = 1'b0;
        mem_done      = 1'b0;
        mem_stall_req = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                mem_stall_req = w_op;
                if (w_op) begin
                    w_state_nxt = w_skip_bus ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                dreq_valid    = 1'b1;
                mem_stall_req = 1'b1;
                if (dreq_ready) begin
                    w_state_nxt = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                mem_stall_req = 1'b1;
                if (dresp_valid) begin
                    w_state_nxt = LSU_DONE;
                end
            end
            LSU_DONE: begin
                mem_done    = 1'b1;
                w_state_nxt = LSU_IDLE;
            end
            default: w_state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr   <= '0;
            r_off    <= '0;
            r_mask   <= '0;
            r_ext_un <= 1'b0;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_rdata  <= '0;
`ifdef MISALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            if (r_state == LSU_IDLE && w_op) begin
                r_addr   <= {me_alu_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                r_off    <= w_off;
                r_mask   <= me_mem_byte_enable;
                r_ext_un <= me_mem_ext_un;
                r_wen    <= me_mem_wena;
                r_wdata  <= w_wdata;
                r_wstrb  <= w_strb;
`ifdef MISALIGN_CHECK_EN
                r_misalign <= w_misalign;
                if (w_misalign) begin
                    r_rdata <= '0;
                end
`endif
            end
            // Store responses only acknowledge the write; their rdata is dropped.
            if (r_state == LSU_WAIT && dresp_valid) begin
                r_rdata <= r_wen ? '0 : w_load_data;
            end
        end
    end

    assign dreq_addr  = r_addr;
    assign dreq_wen   = r_wen;
    assign dreq_wdata = r_wdata;
    assign dreq_wstrb = r_wstrb;
    assign mem_rdata  = r_rdata;

endmodule

// File: tb/tb_me_lsu.sv
module tb_me_lsu;

    logic        clk;
    logic        rst;
    logic        me_mem_rena;
    logic        me_mem_wena;
    logic        me_mem_ext_un;
    logic [7:0]  me_mem_byte_enable;
    logic [63:0] me_alu_result;
    logic [63:0] me_new_rs2_data;
    logic        me_inst_valid;
    logic        dreq_valid;
    logic        dreq_ready = 1'b0;
    logic [63:0] dreq_addr;
    logic        dreq_wen;
    logic [63:0] dreq_wdata;
    logic [7:0]  dreq_wstrb;
    logic        dresp_valid = 1'b0;
    logic [63:0] dresp_rdata = 64'd0;
    logic [63:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall_req;
`ifdef MISALIGN_CHECK_EN
    logic        mem_misalign;
`endif

    me_lsu dut (
        .clk                (clk),
        .rst                (rst),
        .me_mem_rena        (me_mem_rena),
        .me_mem_wena        (me_mem_wena),
        .me_mem_ext_un      (me_mem_ext_un),
        .me_mem_byte_enable (me_mem_byte_enable),
        .me_alu_result      (me_alu_result),
        .me_new_rs2_data    (me_new_rs2_data),
        .me_inst_valid      (me_inst_valid),
        .dreq_valid         (dreq_valid),
        .dreq_ready         (dreq_ready),
        .dreq_addr          (dreq_addr),
        .dreq_wen           (dreq_wen),
        .dreq_wdata         (dreq_wdata),
        .dreq_wstrb         (dreq_wstrb),
        .dresp_valid        (dresp_valid),
        .dresp_rdata        (dresp_rdata),
        .mem_rdata          (mem_rdata),
        .mem_done           (mem_done),
        .mem_stall_req      (mem_stall_req)
`ifdef MISALIGN_CHECK_EN
        ,
        .mem_misalign       (mem_misalign)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] rdata;
        int          rdy_wait;
        int          resp_dly;
    } req_t;

    typedef struct {
        logic [63:0] data;
        logic        mis;
    } res_t;

    req_t req_q[$];
    res_t exp_q[$];
    res_t mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int issue_cyc = 0;
    int done_cyc = 0;
    int n_acc = 0;
    int wait_cnt = 0;
    bit resp_pend = 0;
    int resp_cnt = 0;
    logic [63:0] resp_data = 64'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [7:0] be);
        case (be)
            8'h01:   return 1;
            8'h03:   return 2;
            8'h0F:   return 4;
            default: return 8;
        endcase
    endfunction

    // Reference load: pick bytes off..off+n-1 (none beyond byte 7), then extend.
    function automatic logic [63:0] load_model(input logic [63:0] rd, input int off, input int n,
                                               input logic un);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!un && n < 8 && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // Bus slave: ready after rdy_wait cycles, response resp_dly cycles after
    // the first WAIT cycle. Checks request fields every cycle they are presented.
    always @(negedge clk) begin
        dresp_valid = 1'b0;
        if (resp_pend) begin
            if (resp_cnt == 0) begin
                dresp_valid = 1'b1;
                dresp_rdata = resp_data;
                resp_pend   = 1'b0;
            end else begin
                resp_cnt--;
            end
        end
        dreq_ready = 1'b0;
        if (dreq_valid) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", {63'd0, dreq_valid}, 64'd0);
                dreq_ready = 1'b1;
            end else begin
                chk("dreq_addr", dreq_addr, req_q[0].addr);
                chk("dreq_wen", {63'd0, dreq_wen}, {63'd0, req_q[0].wen});
                if (req_q[0].wen) begin
                    chk("dreq_wdata", dreq_wdata, req_q[0].wdata);
                    chk("dreq_wstrb", {56'd0, dreq_wstrb}, {56'd0, req_q[0].wstrb});
                end
                if (wait_cnt < req_q[0].rdy_wait) begin
                    wait_cnt++;
                end else begin
                    dreq_ready = 1'b1;
                    wait_cnt   = 0;
                    resp_pend  = 1'b1;
                    resp_cnt   = req_q[0].resp_dly;
                    resp_data  = req_q[0].rdata;
                    n_acc++;
                    void'(req_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mem_done) begin
            done_cyc = cyc;
            chk("stall_in_done", {63'd0, mem_stall_req}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {63'd0, mem_done}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mem_rdata", mem_rdata, mon_e.data);
`ifdef MISALIGN_CHECK_EN
                chk("mem_misalign", {63'd0, mem_misalign}, {63'd0, mon_e.mis});
`endif
            end
        end
    end

    task automatic drive_op(input logic valid, input logic rena, input logic wena, input logic un,
                            input logic [7:0] be, input logic [63:0] addr, input logic [63:0] rs2,
                            input logic [63:0] rdata, input int rw, input int rd);
        int n;
        int off;
        bit mis;
        req_t r;
        res_t e;
        me_inst_valid      = valid;
        me_mem_rena        = rena;
        me_mem_wena        = wena;
        me_mem_ext_un      = un;
        me_mem_byte_enable = be;
        me_alu_result      = addr;
        me_new_rs2_data    = rs2;
        issue_cyc          = cyc;
        if (valid && (rena || wena)) begin
            n   = nbytes(be);
            off = int'(addr[2:0]);
            mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
            mis = (off + n > 8) || (off % n != 0);
`endif
            if (mis) begin
                e.data = 64'd0;
                e.mis  = 1'b1;
            end else begin
                r.addr  = {addr[63:3], 3'b000};
                r.wen   = wena;
                r.wdata = 64'd0;
                r.wstrb = 8'd0;
                for (int i = 0; i < 8; i++) begin
                    if (i >= off) begin
                        r.wdata[8*i +: 8] = rs2[8*(i-off) +: 8];
                        if (i < off + n) r.wstrb[i] = 1'b1;
                    end
                end
                r.rdata    = rdata;
                r.rdy_wait = rw;
                r.resp_dly = rd;
                req_q.push_back(r);
                e.data = wena ? 64'd0 : load_model(rdata, off, n, un);
                e.mis  = 1'b0;
            end
            exp_q.push_back(e);
        end
    endtask

    // Drives one instruction at a negedge and holds it while the LSU stalls;
    // nstall counts the cycles mem_stall_req was high.
    task automatic issue(input logic valid, input logic rena, input logic wena, input logic un,
                         input logic [7:0] be, input logic [63:0] addr, input logic [63:0] rs2,
                         input logic [63:0] rdata, input int rw, input int rd, output int nstall);
        @(negedge clk);
        drive_op(valid, rena, wena, un, be, addr, rs2, rdata, rw, rd);
        #1;
        nstall = 0;
        while (mem_stall_req === 1'b1 && nstall < 100) begin
            nstall++;
            @(negedge clk);
            #1;
        end
        if (nstall >= 100) chk("stall_timeout", 64'(nstall), 64'd0);
    endtask

    initial begin
        int ns;
        int base;
        int k;
        int n;
        logic [7:0]  masks [4];
        logic [63:0] a;
        logic v, rn, wn;

        masks = '{8'h01, 8'h03, 8'h0F, 8'hFF};
        rst = 1'b0;
        me_inst_valid = 1'b0; me_mem_rena = 1'b0; me_mem_wena = 1'b0; me_mem_ext_un = 1'b0;
        me_mem_byte_enable = 8'h00; me_alu_result = 64'd0; me_new_rs2_data = 64'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rst_mem_done", {63'd0, mem_done}, 64'd0);
        chk("rst_stall", {63'd0, mem_stall_req}, 64'd0);
        chk("rst_dreq_addr", dreq_addr, 64'd0);
        chk("rst_mem_rdata", mem_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // signed LB with immediate ready/response
        issue(1, 1, 0, 0, 8'h01, 64'h1003, 64'd0, 64'h00000000_80FF0000, 0, 0, ns);
        chk("lb_stall_cycles", 64'(ns), 64'd3);
        chk("lb_done_latency", 64'(done_cyc - issue_cyc), 64'd3);

        // unsigned LHU
        issue(1, 1, 0, 1, 8'h03, 64'h1006, 64'd0, 64'hBEEF0000_00000000, 0, 0, ns);

        // SW at offset 4
        issue(1, 0, 1, 0, 8'h0F, 64'h2004, 64'h11223344, 64'hDEADBEEF_CAFEF00D, 0, 0, ns);

        // back-pressure: ready low for 4 cycles, response one cycle late
        base = n_acc;
        issue(1, 0, 1, 0, 8'hFF, 64'h3000, 64'hA5A5_5A5A_0123_4567, 64'd0, 4, 1, ns);
        chk("bp_accepts", 64'(n_acc - base), 64'd1);
        chk("bp_stall_cycles", 64'(ns), 64'd8);

        // LD, ALU op, SD back to back
        base = n_acc;
        issue(1, 1, 0, 0, 8'hFF, 64'h4008, 64'd0, 64'h8877_6655_4433_2211, 0, 0, ns);
        issue(1, 0, 0, 0, 8'hFF, 64'h4010, 64'd0, 64'd0, 0, 0, ns);
        chk("alu_no_stall", 64'(ns), 64'd0);
        issue(1, 0, 1, 0, 8'hFF, 64'h4010, 64'h0F0E_0D0C_0B0A_0908, 64'd0, 0, 0, ns);
        chk("b2b_accepts", 64'(n_acc - base), 64'd2);

        // signed LH at offset 2, then reset in the middle of a load's WAIT
        issue(1, 1, 0, 0, 8'h03, 64'h5002, 64'd0, 64'h00000000_80010000, 0, 0, ns);
        @(negedge clk);
        base = n_acc;
        drive_op(1, 1, 0, 0, 8'hFF, 64'h6000, 64'd0, 64'h1234_5678_9ABC_DEF0, 0, 6);
        for (int i = 0; i < 20 && n_acc == base; i++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_req_accepted", 64'(n_acc - base), 64'd1);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        me_inst_valid = 1'b0;
        #1;
        chk("midrst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("midrst_dreq_addr", dreq_addr, 64'd0);
        chk("midrst_dreq_wen", {63'd0, dreq_wen}, 64'd0);
        chk("midrst_dreq_wstrb", {56'd0, dreq_wstrb}, 64'd0);
        chk("midrst_dreq_wdata", dreq_wdata, 64'd0);
        chk("midrst_mem_rdata", mem_rdata, 64'd0);
        chk("midrst_mem_done", {63'd0, mem_done}, 64'd0);
        chk("midrst_stall", {63'd0, mem_stall_req}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("late_resp_rdata", mem_rdata, 64'd0);
        chk("late_resp_stall", {63'd0, mem_stall_req}, 64'd0);
        issue(1, 1, 0, 1, 8'h0F, 64'h7004, 64'd0, 64'hCAFEBABE_00000000, 0, 0, ns);
        chk("post_rst_stall_cycles", 64'(ns), 64'd3);

`ifdef MISALIGN_CHECK_EN
        base = n_acc;
        issue(1, 1, 0, 0, 8'h0F, 64'h1002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, ns);
        chk("mis_accepts", 64'(n_acc - base), 64'd0);
        chk("mis_done_latency", 64'(done_cyc - issue_cyc), 64'd1);
`endif

        // randomized mix
        for (int t = 0; t < 300; t++) begin
            k  = $urandom_range(0, 9);
            v  = (k != 0);
            rn = (k == 0) ? 1'($urandom_range(0, 1)) : (k >= 2 && k <= 5) || (k == 9);
            wn = (k >= 6);
            a  = {$urandom, $urandom};
            n  = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) a[2:0] = a[2:0] & ~3'(nbytes(masks[n]) - 1);
            issue(v, rn, wn, 1'($urandom_range(0, 1)), masks[n], a, {$urandom, $urandom},
                  {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3), ns);
            if (!(v && (rn || wn))) chk("nonop_stall", 64'(ns), 64'd0);
        end

        me_inst_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("req_q_drained", 64'(req_q.size()), 64'd0);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/me_lsu.md
Name: me_lsu

Overview:
Memory-stage load/store engine that consumes the EX/MEM pipeline register outputs (me_*) and drives the data-memory bus. It issues one request per memory instruction, waits for the response, aligns and extends load data, and holds the pipeline through the EX/MEM stall input via mem_stall_req until the access completes.

Parameters:
ADDR_W, 64, data-bus address width
DATA_W, 64, data-bus width; one 8-lane strobe per 64-bit word

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (rst == 1'b0 resets)
me_mem_rena  in  1  load
me_mem_wena  in  1  store
me_mem_ext_un  in  1  1 = zero-extend load, 0 = sign-extend
me_mem_byte_enable  in  8  unshifted size mask: 0x01 / 0x03 / 0x0F / 0xFF
me_alu_result  in  64  effective address
me_new_rs2_data  in  64  store data, LSB-aligned
me_inst_valid  in  1  slot holds a real instruction
dreq_valid  out  1  bus request valid
dreq_ready  in  1  bus accepts request
dreq_addr  out  64  {addr[63:3], 3'b000}
dreq_wen  out  1  1 = write
dreq_wdata  out  64  store data shifted to lane
dreq_wstrb  out  8  shifted byte mask
dresp_valid  in  1  response pulse, one cycle
dresp_rdata  in  64  read data, full aligned word
mem_rdata  out  64  aligned, extended load result
mem_done  out  1  one-cycle pulse: access complete, mem_rdata valid
mem_stall_req  out  1  to stall control: hold EX/MEM (STALL_KEEP) while high

Behaviour:
- op = me_inst_valid & (me_mem_rena | me_mem_wena); both rena and wena high is treated as a store.
- States: IDLE, REQ, WAIT, DONE. Encoding is local to the block.
- IDLE: if op, capture addr/size/ext/wen/wdata into internal registers and go to REQ; otherwise stay in IDLE.
- REQ: dreq_valid=1. Address, wen, wdata and wstrb come from the captured registers and stay stable until dreq_valid & dreq_ready, then go to WAIT.
- WAIT: wait for dresp_valid. For stores, the response acknowledges the write and rdata is ignored. On dresp_valid go to DONE.
  - Load: mem_rdata <= extend(dresp_rdata >> (off*8)).
  - Store: mem_rdata <= 0.
- dresp_valid outside WAIT is ignored.
- DONE: mem_done=1 for one cycle, then go to IDLE. The instruction held by EX/MEM advances at the end of this cycle. The next instruction is evaluated in IDLE on the following cycle.
- mem_stall_req = (IDLE & op) | REQ | WAIT. It is combinational from state and op, and is 0 in DONE and when there is no op.
- Alignment:
  - off = addr[2:0]
  - wstrb = (byte_enable << off)[7:0]
  - wdata = rs2 << (off*8)
- Extension: ext_un selects zero- or sign-extension from bit 7 / 15 / 31 for mask 0x01 / 0x03 / 0x0F. Mask 0xFF passes the data unchanged.
- Minimum latency: 3 cycles from op to mem_done, when dreq_ready is high in REQ and dresp_valid arrives the cycle after acceptance.
- Reset values (immediate, asynchronous, also mid-transaction): state=IDLE; dreq_valid, dreq_wen, dreq_wstrb, mem_done = 0; dreq_addr, dreq_wdata, mem_rdata = 0. An outstanding bus response after reset is dropped.

Optional Feature:
MISALIGN_CHECK_EN
- Defined: a request is misaligned if (byte_enable << off) carries beyond bit 7, or off is not a multiple of the access size. A misaligned op skips REQ/WAIT and goes IDLE -> DONE. No bus request is issued, mem_rdata=0, and an extra output mem_misalign pulses with mem_done.
- Undefined: no check and no mem_misalign port. Overflow lanes are truncated silently.

Decomposition:
- defines.v gains:
  - LSU state encodings
  - size-mask constants MASK_B/H/W/D
  - the existing STALL_* codes used by the stall controller that consumes mem_stall_req
- Sub-module me_load_ext: purely combinational shift-and-extend of load data (rdata, off, mask, ext_un -> mem_rdata).

Test Plan:
- Signed LB, addr 0x1003, rdata 0x00000000_80FF0000 (byte 3 = 0x80), ready/resp immediate -> mem_done in cycle 3, mem_rdata=0xFFFFFFFF_FFFFFF80, stall high cycles 0-2.
- Unsigned LHU, addr 0x1006, rdata 0xBEEF0000_00000000 -> mem_rdata=0x000000000000BEEF.
- SW, addr 0x2004, rs2=0x11223344 -> dreq_wstrb=0xF0, dreq_wdata=0x11223344_00000000, dreq_addr=0x2000, dreq_wen=1.
- Back-pressure: dreq_ready low 4 cycles -> dreq_valid and all request fields stable throughout, mem_stall_req high, single acceptance.
- Back-to-back LD then ALU op then SD -> stall releases in each DONE, no stall for the ALU op, exactly 2 bus requests.
- rst low during WAIT -> immediately IDLE with outputs zero, a late dresp_valid is ignored, and the next op proceeds normally. With MISALIGN_CHECK_EN: LW at 0x1002 -> no dreq_valid, mem_done and mem_misalign in cycle 1.
